// File: rtl/alu_op_sched_if.sv
// Request/result bundle between issue logic and the shared operator unit.
// master = issue side, slave = scheduler.
interface alu_op_sched_if #(
  parameter int width = 8,
  parameter int nreq  = 4
);
  localparam int idw = $clog2(nreq);

  logic [nreq-1:0]       req_valid;
  logic [nreq-1:0]       req_ready;
  logic [4*nreq-1:0]     req_op;
  logic [width*nreq-1:0] req_a;
  logic [width*nreq-1:0] req_b;
  logic [width*nreq-1:0] req_c;
  logic                  res_valid;
  logic                  res_ready;
  logic [width-1:0]      res_data;
  logic [idw-1:0]        res_id;
  logic                  res_err;

  modport master (
    output req_valid, req_op, req_a,
    output req_b, req_c, res_ready,
    input  req_ready, res_valid,
    input  res_data, res_id, res_err
  );

  modport slave (
    input  req_valid, req_op, req_a,
    input  req_b, req_c, res_ready,
    output req_ready, res_valid,
    output res_data, res_id, res_err
  );
endinterface

// File: rtl/alu_op_sched.sv
// Round-robin scheduler in front of one shared operator datapath.
// Div/rem use an iterative restoring divider; others take one cycle.
module alu_op_sched #(
  parameter int width = 8,
  parameter int nreq  = 4
) (
  input  logic          clk,
  input  logic          reset,
  alu_op_sched_if.slave bus
);
  localparam int idw = $clog2(nreq);
  localparam int cw  = $clog2(width + 1);
  localparam logic [31:0] wlim = 32'(width);

  typedef enum logic [1:0] {
    IDLE, COMPUTE, DIV, HOLD
  } state_t;

  state_t state, state_nx;

  logic [idw-1:0]   ptr, gnt, id_q;
  logic             found;
  logic [3:0]       op_g, op_q;
  logic [width-1:0] a_q, b_q, c_q;
  logic [cw-1:0]    cnt;
  logic [width:0]   rem, rem_sh;
  logic [width-1:0] quo;
  logic             ge;
  logic [width-1:0] alu_r;
  logic             alu_err;
  logic [width-1:0] data_q;
  logic             err_q;

  // first valid requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < nreq; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= nreq) j -= nreq;
      if (!found && bus.req_valid[j]) begin
        found = 1'b1;
        gnt   = idw'(j);
      end
    end
  end

  assign op_g = bus.req_op[4*int'(gnt) +: 4];

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && found && !reset)
      bus.req_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (found)
          state_nx = (op_g == 4'd3 || op_g == 4'd4)
                   ? DIV : COMPUTE;
      COMPUTE: state_nx = HOLD;
      DIV:
        if (cnt == cw'(width)) state_nx = HOLD;
      HOLD:
        if (bus.res_ready) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    alu_r   = '0;
    alu_err = 1'b0;
    case (op_q)
      4'd0:  alu_r = a_q + b_q;
      4'd1:  alu_r = a_q - b_q;
      4'd2:  alu_r = a_q * b_q;
      4'd5:  alu_r = a_q & b_q;
      4'd6:  alu_r = a_q | b_q;
      4'd7:  alu_r = a_q ^ b_q;
      4'd8:  alu_r = ~(a_q ^ b_q);
      4'd9:
        if (32'(b_q) < wlim) alu_r = a_q >> b_q;
      4'd10:
        if (32'(b_q) < wlim) alu_r = a_q << b_q;
      4'd11: alu_r[0] = a_q < b_q;
      4'd12: alu_r[0] = a_q == b_q;
      4'd13: alu_r = (|a_q) ? b_q : c_q;
      4'd14: alu_r = ~a_q;
      4'd15: alu_err = 1'b1;
      default: alu_r = '0;
    endcase
  end

  // b == 0 falls out naturally: quotient all ones, remainder a
  assign rem_sh = {rem[width-1:0], quo[width-1]};
  assign ge     = rem_sh >= {1'b0, b_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      id_q   <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (found) begin
            ptr  <= (gnt == idw'(nreq - 1))
                  ? '0 : gnt + 1'b1;
            id_q <= gnt;
            op_q <= op_g;
            a_q  <= bus.req_a[width*int'(gnt) +: width];
            b_q  <= bus.req_b[width*int'(gnt) +: width];
            c_q  <= bus.req_c[width*int'(gnt) +: width];
            quo  <= bus.req_a[width*int'(gnt) +: width];
            rem  <= '0;
            cnt  <= '0;
          end
        COMPUTE: begin
          data_q <= alu_r;
          err_q  <= alu_err;
        end
        DIV:
          if (cnt == cw'(width)) begin
            data_q <= (op_q == 4'd3)
                    ? quo : rem[width-1:0];
            err_q  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            rem <= ge ? rem_sh - {1'b0, b_q} : rem_sh;
            quo <= (quo << 1) | width'(ge);
          end
        HOLD: ;
      endcase
    end
  end

  assign bus.res_valid = (state == HOLD);
  assign bus.res_data  = data_q;
  assign bus.res_id    = id_q;
  assign bus.res_err   = err_q;
endmodule

// File: tb/tb_alu_op_sched.sv
// Scoreboard bench for alu_op_sched: directed vectors,
// expected results queued at grant, checked by a monitor.
module tb_alu_op_sched;
  localparam int W = 8;
  localparam int N = 4;

  typedef struct {
    int data;
    int id;
    int err;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  alu_op_sched_if #(.width(W), .nreq(N)) bus();

  alu_op_sched #(.width(W), .nreq(N)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d cyc=%0d",
               nm, got, want, cyc);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout cyc=%0d", nm, cyc);
  endtask

  bit       prev_v = 0;
  bit       prev_r = 0;
  int       prev_d, prev_i, prev_e;

  always @(negedge clk) begin
    exp_t e;
    if (bus.res_valid && !prev_v) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("latency", cyc, sb[0].cyc);
    end
    if (bus.res_valid && prev_v && !prev_r) begin
      chk("stable_data", int'(bus.res_data), prev_d);
      chk("stable_id", int'(bus.res_id), prev_i);
      chk("stable_err", int'(bus.res_err), prev_e);
    end
    if (bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) chk("unexpected_res", 1, 0);
      else begin
        e = sb.pop_front();
        chk("res_data", int'(bus.res_data), e.data);
        chk("res_id", int'(bus.res_id), e.id);
        chk("res_err", int'(bus.res_err), e.err);
      end
    end
    if (!reset) begin
      chk("ready_onehot",
          int'($countones(bus.req_ready) > 1), 0);
      if (bus.res_valid)
        chk("ready_in_hold", int'(bus.req_ready), 0);
    end
    prev_v = bus.res_valid;
    prev_r = bus.res_ready;
    prev_d = int'(bus.res_data);
    prev_i = int'(bus.res_id);
    prev_e = int'(bus.res_err);
  end

  task automatic drive(input int id, input int op,
                       input int a, input int b,
                       input int c);
    bus.req_op[4*id +: 4] = 4'(op);
    bus.req_a[W*id +: W]  = W'(a);
    bus.req_b[W*id +: W]  = W'(b);
    bus.req_c[W*id +: W]  = W'(c);
    bus.req_valid[id]     = 1'b1;
  endtask

  task automatic wait_grant(input int id,
                            output int t, output bit ok);
    ok = 0;
    t  = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        ok = 1;
        t  = cyc;
      end
    end
  endtask

  task automatic issue(input int id, input int op,
                       input int a, input int b,
                       input int c, input int ed,
                       input int ee, input int lat);
    int t;
    bit ok;
    @(posedge clk); #1;
    drive(id, op, a, b, c);
    wait_grant(id, t, ok);
    if (!ok) flag("grant");
    else sb.push_back('{ed, id, ee, t + lat});
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.res_valid) done = 1;
    end
    if (!done) flag("drain");
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int ord[6] = '{0, 1, 2, 3, 0, 1};
    int rr[4]  = '{3, 14, 25, 36};
    int t, last, g;
    bit ok;

    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(bus.res_valid), 0);
    chk("rst_data", int'(bus.res_data), 0);
    chk("rst_id", int'(bus.res_id), 0);
    chk("rst_err", int'(bus.res_err), 0);

    issue(0, 0, 200, 100, 0, 44, 0, 2);
    issue(0, 3, 200, 7, 0, 28, 0, W + 2);
    issue(1, 4, 200, 7, 0, 4, 0, W + 2);
    issue(2, 3, 200, 0, 0, 255, 0, W + 2);
    issue(3, 4, 200, 0, 0, 200, 0, W + 2);
    issue(0, 10, 1, 9, 0, 0, 0, 2);
    issue(1, 13, 0, 5, 9, 9, 0, 2);
    issue(2, 11, 3, 4, 0, 1, 0, 2);
    issue(3, 15, 1, 2, 0, 0, 1, 2);
    issue(0, 2, 12, 25, 0, 44, 0, 2);
    issue(1, 9, 128, 3, 0, 16, 0, 2);
    issue(2, 8, 240, 60, 0, 51, 0, 2);
    issue(3, 14, 90, 0, 0, 165, 0, 2);
    issue(0, 1, 5, 7, 0, 254, 0, 2);
    issue(1, 12, 9, 9, 0, 1, 0, 2);
    issue(2, 13, 4, 5, 9, 5, 0, 2);
    drain();

    // backpressure with a competing requester waiting
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    issue(1, 0, 48, 12, 0, 60, 0, 2);
    drive(2, 0, 1, 1, 0);
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (bus.res_valid) ok = 1;
    end
    if (!ok) flag("bp_valid_rise");
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", int'(bus.res_valid), 1);
      chk("bp_data", int'(bus.res_data), 60);
      chk("bp_id", int'(bus.res_id), 1);
      chk("bp_ready", int'(bus.req_ready), 0);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    issue(2, 0, 1, 1, 0, 2, 0, 2);
    drain();

    // round robin, all requesters valid
    pulse_reset();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++)
      drive(i, 0, 10*i + 1, i + 2, 0);
    last = 0;
    for (int n = 0; n < 6; n++) begin
      ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin
        @(negedge clk);
        if (|bus.req_ready) ok = 1;
      end
      if (!ok) flag("rr_grant");
      else begin
        g = 0;
        for (int i = 0; i < N; i++)
          if (bus.req_ready[i]) g = i;
        chk("rr_order", g, ord[n]);
        if (n > 0) chk("rr_gap", cyc - last, 3);
        last = cyc;
        if (n < 5) sb.push_back('{rr[g], g, 0, cyc + 2});
      end
    end
    pulse_reset();
    @(negedge clk);
    chk("rr_after_reset", int'(bus.req_ready), 1);
    if (bus.req_ready == 4'b0001)
      sb.push_back('{rr[0], 0, 0, cyc + 2});
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();

    // reset in the middle of a divide
    @(posedge clk); #1;
    drive(1, 3, 200, 7, 0);
    wait_grant(1, t, ok);
    if (!ok) flag("div_grant");
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      chk("dr_valid", int'(bus.res_valid), 0);
      chk("dr_outs", int'(bus.res_data) +
          int'(bus.res_id) + int'(bus.res_err), 0);
    end
    issue(3, 1, 50, 8, 0, 42, 0, 2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
